sram_access_controller: RTL

Multi-cycle controller sitting between the MEM stage of the ARM pipeline and the off-chip 16-bit SRAM. It converts one 32-bit load or store from the MEM stage into two sequenced 16-bit SRAM accesses, each with a configurable wait time. While the access is in progress it deasserts `ready`, so the pipeline freezes all stages until the word has been transferred. It works alongside the hazard unit; its stall is independent of hazard stalls.

---
 rtl/arm_mem_pkg.sv | 25 ++
 rtl/sram_wait_counter.sv | 29 ++
 rtl/sram_access_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage to off-chip SRAM path: controller
// state encoding, SRAM bus width, default address window and the CPU byte
// address to SRAM half-word address mapping.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_t;

  localparam int SRAM_DW = 16;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // Half-word address of one half of a 32-bit word; the word index is the
  // byte offset from the base divided by four (modulo 2^32, no range check).
  function automatic logic [31:0] sram_word_addr(input logic [31:0] byte_addr,
                                                 input logic [31:0] base_addr,
                                                 input logic        half);
    return (((byte_addr - base_addr) >> 2) << 1) | {31'd0, half};
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times how long each SRAM half-word access is
// held. It saturates at zero and flags zero to the controlling FSM.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2,
  localparam int CW = $clog2(WAIT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [CW-1:0] count_reg;

  // Reload to WAIT_CYCLES-1 at the start of each half, otherwise count down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CW'(WAIT_CYCLES - 1);
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/sram_access_controller.sv
// Splits one 32-bit MEM-stage load or store into two timed 16-bit SRAM
// accesses (low half, then high half) and holds ready low until done.
module sram_access_controller
  import arm_mem_pkg::*;
#(
  parameter int          ADDR_W      = 18,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  ctrl_state_t state_reg, state_next;

  logic               wr_reg;
  logic [31:0]        addr_reg;
  logic [31:0]        wdata_reg;

  logic [31:0]        rdata_reg, rdata_next;
  logic               ready_reg, ready_next;
  logic [ADDR_W-1:0]  sram_addr_reg, sram_addr_next;
  logic [SRAM_DW-1:0] dq_out_reg, dq_out_next;
  logic               dq_oe_reg, dq_oe_next;
  logic               we_n_reg, we_n_next;
  logic               oe_n_reg, oe_n_next;

  logic               accept;
  logic               in_access;
  logic               cnt_zero;
  logic               op_wr;
  logic [ADDR_W-1:0]  lo_addr_in;
  logic [ADDR_W-1:0]  hi_addr_latched;

  assign accept    = (state_reg == ST_IDLE) && (mem_r_en || mem_w_en);
  assign in_access = (state_reg == ST_LO) || (state_reg == ST_HI);
  // A write wins over a read when both are requested together
  assign op_wr     = accept ? mem_w_en : wr_reg;

  assign lo_addr_in      = ADDR_W'(sram_word_addr(addr, BASE_ADDR, 1'b0));
  assign hi_addr_latched = ADDR_W'(sram_word_addr(addr_reg, BASE_ADDR, 1'b1));

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept || ((state_reg == ST_LO) && cnt_zero)),
    .en   (in_access),
    .zero (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: each half lasts until the wait counter reaches zero
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept)   state_next = ST_LO;
      ST_LO:   if (cnt_zero) state_next = ST_HI;
      ST_HI:   if (cnt_zero) state_next = ST_DONE;
      ST_DONE:               state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  // Output logic: SRAM controls follow the state being entered so they are registered
  always_comb begin
    sram_addr_next = sram_addr_reg;
    dq_out_next    = '0;
    dq_oe_next     = 1'b0;
    we_n_next      = 1'b1;
    oe_n_next      = 1'b1;
    ready_next     = 1'b0;
    rdata_next     = rdata_reg;
    case (state_next)
      ST_LO: begin
        if (accept) sram_addr_next = lo_addr_in;
        we_n_next   = ~op_wr;
        oe_n_next   = op_wr;
        dq_oe_next  = op_wr;
        dq_out_next = op_wr ? (accept ? wdata[15:0] : wdata_reg[15:0]) : '0;
      end
      ST_HI: begin
        sram_addr_next = hi_addr_latched;
        we_n_next      = ~op_wr;
        oe_n_next      = op_wr;
        dq_oe_next     = op_wr;
        dq_out_next    = op_wr ? wdata_reg[31:16] : '0;
      end
      ST_DONE: ready_next = 1'b1;
      default: ;
    endcase
    // Read data is sampled at the end of the last cycle of each half
    if (in_access && cnt_zero && !wr_reg) begin
      if (state_reg == ST_LO) rdata_next[15:0]  = sram_dq_in;
      else                    rdata_next[31:16] = sram_dq_in;
    end
  end

  // Request capture: address, data and direction are frozen when accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      wr_reg    <= mem_w_en;
      addr_reg  <= addr;
      wdata_reg <= wdata;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg     <= '0;
      ready_reg     <= 1'b0;
      sram_addr_reg <= '0;
      dq_out_reg    <= '0;
      dq_oe_reg     <= 1'b0;
      we_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
    end else begin
      rdata_reg     <= rdata_next;
      ready_reg     <= ready_next;
      sram_addr_reg <= sram_addr_next;
      dq_out_reg    <= dq_out_next;
      dq_oe_reg     <= dq_oe_next;
      we_n_reg      <= we_n_next;
      oe_n_reg      <= oe_n_next;
    end
  end

  assign rdata       = rdata_reg;
  assign ready       = ready_reg;
  assign sram_addr   = sram_addr_reg;
  assign sram_dq_out = dq_out_reg;
  assign sram_dq_oe  = dq_oe_reg;
  assign sram_we_n   = we_n_reg;
  assign sram_oe_n   = oe_n_reg;

endmodule
